// File: rtl/car_collision_if.sv
// Scan request, frog/car position buses and collision results shared between
// the multi-car controller side and the collision detector.
interface car_collision_if #(
    parameter int NUM_CARS = 10,
    parameter int POS_W    = 6
);
    logic                      i_Scan_Start;
    logic [POS_W-1:0]          i_Frog_X;
    logic [POS_W-1:0]          i_Frog_Y;
    logic [NUM_CARS*POS_W-1:0] i_Car_X;
    logic [NUM_CARS*POS_W-1:0] i_Car_Y;
    logic                      o_Busy;
    logic                      o_Scan_Done;
    logic                      o_Hit;
    logic [3:0]                o_Hit_Car;
    logic [1:0]                o_Lives;
    logic                      o_Game_Over;

    modport master (
        output i_Scan_Start, i_Frog_X, i_Frog_Y, i_Car_X, i_Car_Y,
        input  o_Busy, o_Scan_Done, o_Hit, o_Hit_Car, o_Lives, o_Game_Over
    );

    modport slave (
        input  i_Scan_Start, i_Frog_X, i_Frog_Y, i_Car_X, i_Car_Y,
        output o_Busy, o_Scan_Done, o_Hit, o_Hit_Car, o_Lives, o_Game_Over
    );
endinterface

// File: rtl/car_collision_detect.sv
// Per-frame collision checker: snapshots frog and car positions, walks one car
// per clock, and tracks hits, lives, post-hit grace and game-over.
//
// state       | meaning
// ------------+---------------------------------------------------------
// S_IDLE      | waiting for a scan request
// S_SCAN      | comparing frog against car idx, one car per clock
// S_REPORT    | one cycle with o_Scan_Done (and o_Hit) asserted
// S_GAME_OVER | terminal, outputs frozen until i_Reset
module car_collision_detect #(
    parameter int NUM_CARS      = 10,
    parameter int POS_W         = 6,
    parameter int c_MAX_X       = 20,
    parameter int CAR_LEN       = 2,
    parameter int c_START_LIVES = 3,
    parameter int c_GRACE_SCANS = 4
) (
    input logic            i_Clk,
    input logic            i_Reset,
    car_collision_if.slave bus
);
    localparam int GW = $clog2(c_GRACE_SCANS + 1);

    localparam logic [1:0] S_IDLE      = 2'd0;
    localparam logic [1:0] S_SCAN      = 2'd1;
    localparam logic [1:0] S_REPORT    = 2'd2;
    localparam logic [1:0] S_GAME_OVER = 2'd3;

    localparam logic [POS_W:0]  WRAP        = (POS_W+1)'(c_MAX_X + 1);
    localparam logic [POS_W:0]  LEN         = (POS_W+1)'(CAR_LEN);
    localparam logic [3:0]      LAST_IDX    = 4'(NUM_CARS - 1);
    localparam logic [GW-1:0]   GRACE_LOAD  = GW'(c_GRACE_SCANS);
    localparam logic [1:0]      START_LIVES = 2'(c_START_LIVES);

    logic [1:0]                state;
    logic [3:0]                idx;
    logic [GW-1:0]             grace;
    logic [POS_W-1:0]          snap_frog_x;
    logic [POS_W-1:0]          snap_frog_y;
    logic [NUM_CARS*POS_W-1:0] snap_car_x;
    logic [NUM_CARS*POS_W-1:0] snap_car_y;

    logic                      scan_done;
    logic                      hit;
    logic [3:0]                hit_car;
    logic [1:0]                lives;
    logic                      game_over;

    logic [POS_W-1:0]          car_x;
    logic [POS_W-1:0]          car_y;
    logic [POS_W:0]            d_raw;
    logic [POS_W:0]            d;
    logic                      car_hit;

    // Distance from the car's tail to the frog, folded onto the wrapped X axis.
    always_comb begin
        car_x   = snap_car_x[idx*POS_W +: POS_W];
        car_y   = snap_car_y[idx*POS_W +: POS_W];
        d_raw   = {1'b0, snap_frog_x} - {1'b0, car_x};
        d       = d_raw[POS_W] ? (d_raw + WRAP) : d_raw;
        car_hit = (car_y == snap_frog_y) && (d < LEN);
    end

    always_ff @(posedge i_Clk) begin
        if (i_Reset) begin
            state     <= S_IDLE;
            idx       <= '0;
            grace     <= '0;
            scan_done <= 1'b0;
            hit       <= 1'b0;
            hit_car   <= '0;
            lives     <= START_LIVES;
            game_over <= 1'b0;
        end else begin
            scan_done <= 1'b0;
            hit       <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (bus.i_Scan_Start) begin
                        snap_frog_x <= bus.i_Frog_X;
                        snap_frog_y <= bus.i_Frog_Y;
                        snap_car_x  <= bus.i_Car_X;
                        snap_car_y  <= bus.i_Car_Y;
                        idx         <= '0;
                        state       <= S_SCAN;
                    end
                end
                S_SCAN: begin
                    if (car_hit || (idx == LAST_IDX)) begin
                        state     <= S_REPORT;
                        scan_done <= 1'b1;
                        if (car_hit && (grace == '0)) begin
                            hit     <= 1'b1;
                            hit_car <= idx;
                            grace   <= GRACE_LOAD;
                            lives   <= lives - 2'd1;
                            if (lives == 2'd1)
                                game_over <= 1'b1;
                        end else if (grace != '0) begin
                            grace <= grace - GW'(1);
                        end
                    end else begin
                        idx <= idx + 4'd1;
                    end
                end
                S_REPORT: begin
                    state <= game_over ? S_GAME_OVER : S_IDLE;
                end
                default: begin
                    state <= S_GAME_OVER;
                end
            endcase
        end
    end

    assign bus.o_Busy      = (state == S_SCAN) || (state == S_REPORT);
    assign bus.o_Scan_Done = scan_done;
    assign bus.o_Hit       = hit;
    assign bus.o_Hit_Car   = hit_car;
    assign bus.o_Lives     = lives;
    assign bus.o_Game_Over = game_over;
endmodule

// File: tb/tb_car_collision_detect.sv
// Directed vector bench for car_collision_detect: scan latency, hit reporting,
// wrap, grace window, game-over freeze and mid-scan reset.
module tb_car_collision_detect;
    localparam int NC = 10;
    localparam int PW = 6;

    typedef struct {
        bit               rst;
        logic [PW-1:0]    fx;
        logic [PW-1:0]    fy;
        logic [NC*PW-1:0] cx;
        logic [NC*PW-1:0] cy;
        int               e_lat;
        int               e_hit;
        int               e_car;
        int               e_lives;
        int               e_go;
    } vec_t;

    logic clk;
    logic rst;
    int   checks;
    int   errors;

    car_collision_if #(.NUM_CARS(NC), .POS_W(PW)) bus ();

    car_collision_detect dut (
        .i_Clk   (clk),
        .i_Reset (rst),
        .bus     (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input int exp);
        checks++;
        if (act !== 32'(exp)) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    function automatic logic [NC*PW-1:0] put(input logic [NC*PW-1:0] b, input int i,
                                             input int v);
        b[i*PW +: PW] = PW'(v);
        return b;
    endfunction

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic chk_reset_vals(input string pfx);
        chk({pfx, "_busy"},  32'(bus.o_Busy), 0);
        chk({pfx, "_done"},  32'(bus.o_Scan_Done), 0);
        chk({pfx, "_hit"},   32'(bus.o_Hit), 0);
        chk({pfx, "_car"},   32'(bus.o_Hit_Car), 0);
        chk({pfx, "_lives"}, 32'(bus.o_Lives), 3);
        chk({pfx, "_go"},    32'(bus.o_Game_Over), 0);
    endtask

    // Inputs are scrambled right after the start edge so a design that does
    // not snapshot would see a hit on car 0.
    task automatic run_vec(input vec_t v, input string nm);
        int n;
        bit done;
        if (v.rst) do_reset();
        @(negedge clk);
        bus.i_Frog_X     = v.fx;
        bus.i_Frog_Y     = v.fy;
        bus.i_Car_X      = v.cx;
        bus.i_Car_Y      = v.cy;
        bus.i_Scan_Start = 1'b1;
        @(negedge clk);
        bus.i_Scan_Start = 1'b0;
        bus.i_Car_X      = {NC{v.fx}};
        bus.i_Car_Y      = {NC{v.fy}};
        n    = 0;
        done = 1'b0;
        while (!done && n < 40) begin
            @(negedge clk);
            n++;
            if (bus.o_Scan_Done) done = 1'b1;
        end
        chk({nm, "_lat"},   done ? 32'(n + 1) : 32'hFFFF_FFFF, v.e_lat);
        chk({nm, "_hit"},   32'(bus.o_Hit), v.e_hit);
        chk({nm, "_car"},   32'(bus.o_Hit_Car), v.e_car);
        chk({nm, "_lives"}, 32'(bus.o_Lives), v.e_lives);
        chk({nm, "_go"},    32'(bus.o_Game_Over), v.e_go);
        chk({nm, "_busy"},  32'(bus.o_Busy), 1);
    endtask

    vec_t             tbl[10];
    vec_t             v;
    logic [NC*PW-1:0] cx_def;
    logic [NC*PW-1:0] cy_def;
    logic [NC*PW-1:0] cx_v1;
    logic [NC*PW-1:0] cy_v1;
    bit               seen_busy;
    bit               seen_done;

    initial begin
        checks = 0;
        errors = 0;
        rst    = 1'b0;
        for (int i = 0; i < NC; i++) begin
            cx_def = put(cx_def, i, 2 * i);
            cy_def = put(cy_def, i, 30);
        end
        cx_v1 = put(put(cx_def, 2, 6), 0, 0);
        cy_v1 = put(put(cy_def, 2, 12), 0, 12);

        //          rst fx  fy  cx      cy      lat hit car lives go
        tbl[0] = '{1, 5,  12, cx_def, cy_def, 11, 0, 0, 3, 0};
        tbl[1] = '{0, 7,  12, cx_v1,  cy_v1,  4,  1, 2, 2, 0};
        tbl[2] = '{0, 7,  12, cx_v1,  cy_v1,  4,  0, 2, 2, 0};
        tbl[3] = '{0, 7,  12, cx_v1,  cy_v1,  4,  0, 2, 2, 0};
        tbl[4] = '{0, 7,  12, cx_v1,  cy_v1,  4,  0, 2, 2, 0};
        tbl[5] = '{0, 7,  12, cx_v1,  cy_v1,  4,  0, 2, 2, 0};
        tbl[6] = '{0, 7,  12, cx_v1,  cy_v1,  4,  1, 2, 1, 0};
        // wrap hit on car 1 (car 5 also overlaps but is later in scan order)
        tbl[7] = '{1, 0,  11, put(put(cx_def, 1, 20), 5, 0),
                   put(put(cy_def, 1, 11), 5, 11), 3, 1, 1, 2, 0};
        tbl[8] = '{0, 20, 11, put(cx_def, 1, 0), put(cy_def, 1, 11), 11, 0, 1, 2, 0};
        // d == CAR_LEN on car 3 misses; car 4 overlaps but grace suppresses it
        tbl[9] = '{0, 7,  11, put(put(cx_def, 3, 5), 4, 7),
                   put(put(cy_def, 3, 11), 4, 11), 6, 0, 1, 2, 0};

        bus.i_Scan_Start = 1'b0;
        bus.i_Frog_X     = '0;
        bus.i_Frog_Y     = '0;
        bus.i_Car_X      = cx_def;
        bus.i_Car_Y      = cy_def;

        do_reset();
        chk_reset_vals("por");

        for (int i = 0; i < 10; i++)
            run_vec(tbl[i], $sformatf("v%0d", i));

        // Mid-scan: extra start pulse during SCAN, then reset before completion.
        @(negedge clk);
        bus.i_Frog_X     = 6'd5;
        bus.i_Frog_Y     = 6'd12;
        bus.i_Car_X      = cx_def;
        bus.i_Car_Y      = cy_def;
        bus.i_Scan_Start = 1'b1;
        @(negedge clk);
        bus.i_Scan_Start = 1'b0;
        repeat (2) @(negedge clk);
        chk("mid_busy", 32'(bus.o_Busy), 1);
        bus.i_Scan_Start = 1'b1;
        @(negedge clk);
        bus.i_Scan_Start = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk_reset_vals("midrst");
        seen_busy = 1'b0;
        seen_done = 1'b0;
        repeat (15) begin
            @(negedge clk);
            if (bus.o_Busy) seen_busy = 1'b1;
            if (bus.o_Scan_Done) seen_done = 1'b1;
        end
        chk("drop_busy", 32'(seen_busy), 0);
        chk("drop_done", 32'(seen_done), 0);

        // Three unsuppressed hits, four suppressed scans between each.
        for (int i = 0; i < 11; i++) begin
            v = '{0, 7, 12, cx_v1, cy_v1, 4, (i % 5 == 0) ? 1 : 0, 2,
                  2 - i / 5, (i == 10) ? 1 : 0};
            run_vec(v, $sformatf("g%0d", i));
        end

        @(negedge clk);
        bus.i_Scan_Start = 1'b1;
        @(negedge clk);
        bus.i_Scan_Start = 1'b0;
        seen_busy = bus.o_Busy;
        seen_done = bus.o_Scan_Done;
        repeat (20) begin
            @(negedge clk);
            if (bus.o_Busy) seen_busy = 1'b1;
            if (bus.o_Scan_Done) seen_done = 1'b1;
        end
        chk("go_busy",  32'(seen_busy), 0);
        chk("go_done",  32'(seen_done), 0);
        chk("go_hit",   32'(bus.o_Hit), 0);
        chk("go_lives", 32'(bus.o_Lives), 0);
        chk("go_level", 32'(bus.o_Game_Over), 1);
        chk("go_car",   32'(bus.o_Hit_Car), 2);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/car_collision_detect.md
# car_collision_detect

Frame-rate collision checker that sits directly downstream of the multi-car controller. On each scan request it snapshots the flattened car position buses and the frog position. It then compares the frog against one car per clock. It reports hits, tracks remaining lives and a post-hit grace window, and latches game-over for the game-state and VGA layers.

## Interface
Parameters:
- NUM_CARS, 10, number of cars packed on the position buses
- POS_W, 6, bits per packed X/Y field
- c_MAX_X, 20, largest car X value; the X axis wraps modulo c_MAX_X+1
- CAR_LEN, 2, cells a car occupies, from X to X+CAR_LEN-1 with wrap
- c_START_LIVES, 3, lives loaded at reset
- c_GRACE_SCANS, 4, completed scans after a hit during which hits are suppressed

Ports:
- i_Clk  in  1  system clock
- i_Reset  in  1  synchronous, active-high reset
- i_Scan_Start  in  1  one-cycle scan request (frame tick)
- i_Frog_X  in  POS_W  frog column
- i_Frog_Y  in  POS_W  frog row
- i_Car_X  in  NUM_CARS*POS_W  car i X at [i*POS_W +: POS_W]
- i_Car_Y  in  NUM_CARS*POS_W  car i Y at [i*POS_W +: POS_W]
- o_Busy  out  1  high in SCAN and REPORT
- o_Scan_Done  out  1  one-cycle pulse at the end of every scan
- o_Hit  out  1  one-cycle pulse, coincident with o_Scan_Done, when an unsuppressed hit occurred
- o_Hit_Car  out  4  index of the car that hit; held until the next hit
- o_Lives  out  2  remaining lives
- o_Game_Over  out  1  level; high once lives reach 0

## Operation
- States:
  - IDLE: waits for a scan request.
  - SCAN: compares one car per cycle.
  - REPORT: one cycle; reports results.
  - GAME_OVER: terminal.
- IDLE, i_Scan_Start=1 → registers snapshot of i_Frog_X/Y and i_Car_X/Y, clears the index and hit flag, then → SCAN. i_Scan_Start is ignored in every other state (no queuing).
- SCAN, index k:
  - Compute d = (frog_X − car_X[k]) in POS_W+1 bits; add c_MAX_X+1 if negative.
  - Hit when car_Y[k] == frog_Y and d < CAR_LEN.
  - On hit: latch k and → REPORT immediately; higher-index cars are not checked.
  - No hit and k == NUM_CARS−1 → REPORT; otherwise k+1.
- REPORT:
  - o_Scan_Done=1.
  - If a hit occurred and grace == 0:
    - o_Hit=1, o_Hit_Car=k, lives−1, grace=c_GRACE_SCANS.
    - If lives was 1: lives=0, o_Game_Over=1, → GAME_OVER.
  - Otherwise, if grace > 0, grace−1; this applies whether or not a hit was found. A suppressed hit does not reload grace.
  - → IDLE unless game over.
- GAME_OVER: o_Busy=0, outputs frozen; left only by i_Reset.
- Snapshot isolation: car or frog changes during SCAN do not affect the current result.

## Timing
- Reset, synchronous and dominant over all other inputs, including mid-scan:
  - state=IDLE, o_Busy=0, o_Scan_Done=0, o_Hit=0, o_Hit_Car=0, o_Lives=c_START_LIVES, o_Game_Over=0, grace=0, index=0.
- Start sampled at edge E0 → SCAN from E0; car k compared in the cycle after edge E0+k.
- Hit on car k: o_Hit, o_Scan_Done valid in the cycle after edge E0+k+1, i.e. latency k+2 cycles from the request cycle.
- No hit: o_Scan_Done after NUM_CARS+1 edges (11 for defaults).
- o_Lives and o_Game_Over update on the same edge that raises o_Hit.
- o_Busy falls on the same edge as o_Scan_Done deasserts. The earliest next accepted start is the cycle after o_Scan_Done.
- Wrap:
  - car_X=20, frog_X=0 gives d=1 → hit for CAR_LEN=2.
  - car_X=0, frog_X=20 gives d=20 → no hit.

## Test plan
- Reset, then frog (5,12), all cars on other rows → o_Scan_Done 11 cycles after start; o_Hit=0; o_Lives=3.
- Frog (7,12), car 2 at (6,12), car 0 at (0,12) → o_Hit and o_Scan_Done 4 cycles after start; o_Hit_Car=2; o_Lives=2.
- Wrap: car 1 at (20,11), frog (0,11) → hit on car 1. Then frog (20,11) with car 1 at (0,11) → no hit.
- Grace: hit, then 4 scans with the frog still on a car → no o_Hit and o_Lives stays 2. The 5th scan → o_Hit and o_Lives=1.
- Three unsuppressed hits → o_Lives=0 and o_Game_Over=1. A later i_Scan_Start leaves o_Busy=0 and produces no o_Scan_Done.
- i_Reset asserted mid-SCAN, and i_Scan_Start pulsed during SCAN → all outputs return to reset values the next cycle. The pulse during SCAN is dropped.
